// File: rtl/data_ram_loader_pkg.sv
// data_ram_loader_pkg: loader state encoding and tile geometry shared with buffer and compute
package data_ram_loader_pkg;
  localparam int TILE_BYTES = 64;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, LAST = 2'd2, FULL = 2'd3} state_t;
endpackage

// File: rtl/data_ram_loader.sv
// data_ram_loader: streams bytes into the feature buffer and hands full tiles to compute
module data_ram_loader import data_ram_loader_pkg::*; #(
  parameter int DEPTH = TILE_BYTES,
  parameter int DW = 8,
  parameter int AW = $clog2(DEPTH),
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            clear,
  input  logic            s_valid,
  input  logic [DW-1:0]   s_data,
  output logic            s_ready,
  output logic            ram_wen,
  output logic [AW-1:0]   ram_waddr,
  output logic [DW-1:0]   ram_din,
  output logic            tile_valid,
  input  logic            tile_done,
  output logic            loading,
  output logic [CNTW-1:0] tiles_loaded
);
  state_t state;
  logic [AW-1:0] cnt;
  logic hs, at_end;
  assign s_ready = state == LOAD;
  assign tile_valid = state == FULL;
  assign loading = state == LOAD || state == LAST;
  assign hs = s_valid & s_ready;
  assign at_end = cnt == AW'(DEPTH - 1);
  // the write stage runs outside the clear branch so a clear-cycle handshake still lands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      tiles_loaded <= '0;
      ram_wen <= 1'b0;
      ram_waddr <= '0;
      ram_din <= '0;
    end else begin
      ram_wen <= hs;
      if (hs) begin
        ram_waddr <= cnt;
        ram_din <= s_data;
      end
      if (clear) begin
        state <= IDLE;
        cnt <= '0;
      end else begin
        case (state)
          IDLE: if (enable) state <= LOAD;
          LOAD: if (hs) begin
            cnt <= at_end ? '0 : cnt + 1'b1;
            if (at_end) state <= LAST;
          end
          LAST: begin
            state <= FULL;
            tiles_loaded <= tiles_loaded + 1'b1;
          end
          FULL: if (tile_done) state <= enable ? LOAD : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
